// File: rtl/conv_pkg.sv
// Shared geometry constants and FSM state encoding for the conv pass sequencer.
package conv_pkg;

  localparam int unsigned IMG_W = 12;
  localparam int unsigned K     = 5;
  localparam int unsigned OW    = IMG_W - K + 1;
  localparam int unsigned NPIX  = IMG_W * IMG_W;
  localparam int unsigned NOUT  = OW * OW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/conv_pass_addr_gen.sv
// Per-pass pixel/output counters and the feature-map / output-buffer address math.
module conv_pass_addr_gen #(
  parameter int unsigned NPIX   = conv_pkg::NPIX,
  parameter int unsigned NOUT   = conv_pkg::NOUT,
  parameter int unsigned CH_W   = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned PIX_W  = $clog2(NPIX + 1),
  parameter int unsigned OUT_W  = $clog2(NOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_pix_inc,
  input  logic              i_out_inc,
  input  logic [CH_W-1:0]   i_in_ch,
  input  logic [CH_W-1:0]   i_out_ch,
  output logic [PIX_W-1:0]  o_pix_cnt,
  output logic [OUT_W-1:0]  o_out_cnt,
  output logic [ADDR_W-1:0] o_fm_rd_addr,
  output logic [ADDR_W-1:0] o_wr_addr
);

  logic [PIX_W-1:0] r_pix_cnt;
  logic [OUT_W-1:0] r_out_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_pix_cnt <= '0;
      r_out_cnt <= '0;
    end else begin
      if (i_pix_inc) r_pix_cnt <= r_pix_cnt + PIX_W'(1);
      if (i_out_inc) r_out_cnt <= r_out_cnt + OUT_W'(1);
    end
  end

  assign o_pix_cnt = r_pix_cnt;
  assign o_out_cnt = r_out_cnt;

  // Arithmetic deliberately wraps at ADDR_W bits.
  assign o_fm_rd_addr = ADDR_W'(i_in_ch) * ADDR_W'(NPIX) + ADDR_W'(r_pix_cnt);
  assign o_wr_addr    = ADDR_W'(i_out_ch) * ADDR_W'(NOUT) + ADDR_W'(r_out_cnt);

endmodule

// File: rtl/conv_pass_sequencer.sv
// Layer sequencer for the streaming conv engine: walks out/in channel passes, feeds one
// image per pass and routes the valid engine outputs to the output buffer.
module conv_pass_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = conv_pkg::IMG_W,
  parameter int unsigned K      = conv_pkg::K,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CH_W   = 4,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CH_W-1:0]   num_in_ch,
  input  logic [CH_W-1:0]   num_out_ch,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              fm_rd_en,
  output logic [ADDR_W-1:0] fm_rd_addr,
  input  logic [DATA_W-1:0] fm_rd_data,
  output logic              eng_reset,
  output logic              eng_valid,
  output logic [DATA_W-1:0] eng_data,
  output logic [2*CH_W-1:0] eng_kernel_sel,
  input  logic [ACC_W-1:0]  eng_out,
  input  logic              eng_invalid,
  input  logic              eng_finish,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ACC_W-1:0]  wr_data,
  output logic              wr_acc
);

  localparam int unsigned L_NPIX = IMG_W * IMG_W;
  localparam int unsigned L_OW   = IMG_W - K + 1;
  localparam int unsigned L_NOUT = L_OW * L_OW;
  localparam int unsigned L_TMO  = 4 * L_NPIX;
  localparam int unsigned PIX_W  = $clog2(L_NPIX + 1);
  localparam int unsigned OUT_W  = $clog2(L_NOUT + 1);
  localparam int unsigned TMO_W  = $clog2(L_TMO);

  state_t           r_state, w_state_nxt;
  logic [CH_W-1:0]  r_num_in, r_num_out, r_in_ch, r_out_ch;
  logic             r_err, r_eng_valid;
  logic [TMO_W-1:0] r_drain_cnt;
  logic [PIX_W-1:0] w_pix_cnt;
  logic [OUT_W-1:0] w_out_cnt, w_out_cnt_fin;
  logic             w_clear, w_capture, w_hit, w_overflow, w_short;
  logic             w_last_pix, w_last_in, w_last_out, w_timeout;

  assign w_last_pix = (w_pix_cnt == PIX_W'(L_NPIX - 1));
  assign w_last_in  = (r_in_ch == r_num_in);
  assign w_last_out = (r_out_ch == r_num_out);
  assign w_timeout  = (r_drain_cnt == TMO_W'(L_TMO - 1)) && !eng_finish;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    fm_rd_en    = 1'b0;
    eng_reset   = reset;
    w_clear     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_CLEAR;
      S_CLEAR: begin
        busy        = !reset;
        eng_reset   = 1'b1;
        w_clear     = 1'b1;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        busy      = !reset;
        fm_rd_en  = !reset;
        w_capture = 1'b1;
        if (w_last_pix) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = !reset;
        w_capture = 1'b1;
        if (eng_finish || w_timeout) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        busy        = !reset;
        w_state_nxt = (w_last_in && w_last_out) ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done        = !reset;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_hit         = w_capture && !eng_invalid && !reset;
  assign wr_en         = w_hit && (w_out_cnt < OUT_W'(L_NOUT));
  assign w_overflow    = w_hit && !wr_en;
  assign w_out_cnt_fin = w_out_cnt + OUT_W'(wr_en);
  assign w_short       = (r_state == S_DRAIN) && eng_finish && (w_out_cnt_fin != OUT_W'(L_NOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_in    <= '0;
      r_num_out   <= '0;
      r_in_ch     <= '0;
      r_out_ch    <= '0;
      r_err       <= 1'b0;
      r_eng_valid <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_eng_valid <= fm_rd_en;
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + TMO_W'(1) : '0;
      if (r_state == S_IDLE && start) begin
        r_num_in  <= num_in_ch;
        r_num_out <= num_out_ch;
        r_in_ch   <= '0;
        r_out_ch  <= '0;
        r_err     <= 1'b0;
      end
      if (r_state == S_NEXT) begin
        if (!w_last_in) begin
          r_in_ch <= r_in_ch + CH_W'(1);
        end else begin
          r_in_ch  <= '0;
          r_out_ch <= w_last_out ? '0 : r_out_ch + CH_W'(1);
        end
      end
      if (w_overflow || w_short || (r_state == S_DRAIN && w_timeout)) r_err <= 1'b1;
    end
  end

  conv_pass_addr_gen #(
    .NPIX   (L_NPIX),
    .NOUT   (L_NOUT),
    .CH_W   (CH_W),
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W),
    .OUT_W  (OUT_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_clear),
    .i_pix_inc    (fm_rd_en),
    .i_out_inc    (wr_en),
    .i_in_ch      (r_in_ch),
    .i_out_ch     (r_out_ch),
    .o_pix_cnt    (w_pix_cnt),
    .o_out_cnt    (w_out_cnt),
    .o_fm_rd_addr (fm_rd_addr),
    .o_wr_addr    (wr_addr)
  );

  // Read data already lands one cycle after the strobe, so it pairs with the delayed valid.
  assign eng_valid      = r_eng_valid;
  assign eng_data       = r_eng_valid ? fm_rd_data : '0;
  assign eng_kernel_sel = {r_out_ch, r_in_ch};
  assign err            = r_err;
  assign wr_data        = wr_en ? eng_out : '0;
  assign wr_acc         = wr_en && (r_in_ch != '0);

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Directed bench for conv_pass_sequencer with a feature-map memory and a simple engine model.
module tb_conv_pass_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_in_ch = '0;
  logic [3:0]  num_out_ch = '0;
  logic        busy, done, err, fm_rd_en, eng_reset, eng_valid, wr_en, wr_acc;
  logic [11:0] fm_rd_addr, wr_addr;
  logic [15:0] fm_rd_data = '0;
  logic [15:0] eng_data;
  logic [7:0]  eng_kernel_sel;
  logic [31:0] eng_out, wr_data;
  logic        eng_invalid, eng_finish;

  always #5 clk = ~clk;

  conv_pass_sequencer #(
    .IMG_W(12), .K(5), .DATA_W(16), .ACC_W(32), .CH_W(4), .ADDR_W(12)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_in_ch(num_in_ch), .num_out_ch(num_out_ch),
    .busy(busy), .done(done), .err(err),
    .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
    .eng_reset(eng_reset), .eng_valid(eng_valid), .eng_data(eng_data),
    .eng_kernel_sel(eng_kernel_sel), .eng_out(eng_out), .eng_invalid(eng_invalid),
    .eng_finish(eng_finish),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_acc(wr_acc)
  );

  int total = 0;
  int bad = 0;

  // Feature map holds its own address as pixel value.
  always @(posedge clk) if (fm_rd_en === 1'b1) fm_rd_data <= {4'h0, fm_rd_addr};

  // Engine model: valid output for every pixel completing a 5x5 window, tagged with sel and pixel.
  localparam int M_NORMAL = 0, M_SHORT = 1, M_NOFIN = 2;
  int          mode = M_NORMAL;
  int          m_rx = 0;
  int          m_fin_cnt = 0;
  logic        m_inv = 1'b1;
  logic        m_fin = 1'b0;
  logic [31:0] m_out = '0;
  assign eng_invalid = m_inv;
  assign eng_finish  = m_fin;
  assign eng_out     = m_out;

  always @(posedge clk) begin
    if (eng_reset === 1'b1) begin
      m_rx <= 0; m_inv <= 1'b1; m_fin <= 1'b0; m_fin_cnt <= 0;
    end else begin
      m_inv <= 1'b1;
      m_fin <= 1'b0;
      if (eng_valid === 1'b1) begin
        if ((m_rx / 12) >= 4 && (m_rx % 12) >= 4 && !(mode == M_SHORT && m_rx == 143)) begin
          m_inv <= 1'b0;
          m_out <= {8'h00, eng_kernel_sel, 16'(m_rx)};
        end
        m_rx <= m_rx + 1;
        if (m_rx == 143) m_fin_cnt <= 3;
      end
      if (m_fin_cnt != 0) begin
        m_fin_cnt <= m_fin_cnt - 1;
        if (m_fin_cnt == 1 && mode != M_NOFIN) m_fin <= 1'b1;
      end
    end
  end

  typedef struct {logic [11:0] a; logic [31:0] d; logic acc;} wr_t;
  logic [11:0] rd_q[$];
  logic [15:0] ev_q[$];
  wr_t         wr_q[$];
  logic [7:0]  clr_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (fm_rd_en === 1'b1) rd_q.push_back(fm_rd_addr);
    if (eng_valid === 1'b1) ev_q.push_back(eng_data);
    if (wr_en === 1'b1) wr_q.push_back('{a: wr_addr, d: wr_data, acc: wr_acc});
    if (eng_reset === 1'b1 && reset === 1'b0) clr_q.push_back(eng_kernel_sel);
    if (done === 1'b1) done_cnt++;
  end

  function automatic int pix_of(int k);
    return (k / 8 + 4) * 12 + (k % 8 + 4);
  endfunction

  task automatic do_start(input logic [3:0] nin, input logic [3:0] nout);
    @(negedge clk);
    start = 1'b1; num_in_ch = nin; num_out_ch = nout;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = M_NORMAL;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (wr_en !== 1'b0)     begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    total++; if (fm_rd_en !== 1'b0)  begin bad++; $display("FAIL reset_fm_rd_en got=%b exp=0", fm_rd_en); end
    total++; if (eng_valid !== 1'b0) begin bad++; $display("FAIL reset_eng_valid got=%b exp=0", eng_valid); end
    total++; if (eng_reset !== 1'b1) begin bad++; $display("FAIL reset_eng_reset got=%b exp=1", eng_reset); end
    total++; if (eng_kernel_sel !== 8'h00) begin bad++; $display("FAIL reset_sel got=%h exp=00", eng_kernel_sel); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (eng_reset !== 1'b0) begin bad++; $display("FAIL idle_eng_reset got=%b exp=0", eng_reset); end
  endtask

  task automatic test_single();
    int rb, eb, wb, cb, db, nb;
    bit got;
    mode = M_NORMAL;
    rb = rd_q.size(); eb = ev_q.size(); wb = wr_q.size(); cb = clr_q.size(); db = done_cnt;
    do_start(4'd0, 4'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    total++; if (eng_reset !== 1'b1) begin bad++; $display("FAIL single_clear got=%b exp=1", eng_reset); end
    wait_done(400, got);
    total++; if (!got) begin bad++; $display("FAIL single_done_wait got=timeout exp=done"); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_done got=%b exp=0", busy); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%b exp=0", done); end
    total++; if (done_cnt - db != 1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt - db); end
    total++; if (rd_q.size() - rb != 144) begin bad++; $display("FAIL single_rd_cnt got=%0d exp=144", rd_q.size() - rb); end
    total++; if (ev_q.size() - eb != 144) begin bad++; $display("FAIL single_valid_cnt got=%0d exp=144", ev_q.size() - eb); end
    total++; if (wr_q.size() - wb != 64) begin bad++; $display("FAIL single_wr_cnt got=%0d exp=64", wr_q.size() - wb); end
    total++; if (clr_q.size() - cb != 1) begin bad++; $display("FAIL single_clr_cnt got=%0d exp=1", clr_q.size() - cb); end
    if (rd_q.size() - rb == 144 && ev_q.size() - eb == 144) begin
      nb = 0;
      for (int i = 0; i < 144; i++)
        if (rd_q[rb+i] !== 12'(i) || ev_q[eb+i] !== 16'(i)) begin
          if (nb == 0) $display("FAIL single_rd_seq idx=%0d got addr=%0d data=%0d exp=%0d", i, rd_q[rb+i], ev_q[eb+i], i);
          nb++;
        end
      total++; if (nb != 0) bad++;
    end
    if (wr_q.size() - wb == 64) begin
      nb = 0;
      for (int k = 0; k < 64; k++)
        if (wr_q[wb+k].a !== 12'(k) || wr_q[wb+k].acc !== 1'b0 || wr_q[wb+k].d !== {16'h0000, 16'(pix_of(k))}) begin
          if (nb == 0) $display("FAIL single_wr idx=%0d got a=%0d d=%h acc=%b exp a=%0d d=%h acc=0",
                                k, wr_q[wb+k].a, wr_q[wb+k].d, wr_q[wb+k].acc, k, pix_of(k));
          nb++;
        end
      total++; if (nb != 0) bad++;
    end
  endtask

  task automatic test_multi();
    int rb, eb, wb, cb, nb_c, nb_r, nb_a, nb_d, nb_k;
    bit got;
    logic [7:0]  sel;
    logic [31:0] ed;
    mode = M_NORMAL;
    rb = rd_q.size(); eb = ev_q.size(); wb = wr_q.size(); cb = clr_q.size();
    do_start(4'd2, 4'd1);
    wait_done(2000, got);
    total++; if (!got) begin bad++; $display("FAIL multi_done_wait got=timeout exp=done"); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL multi_err got=%b exp=0", err); end
    @(negedge clk);
    total++; if (clr_q.size() - cb != 6) begin bad++; $display("FAIL multi_clr_cnt got=%0d exp=6", clr_q.size() - cb); end
    total++; if (rd_q.size() - rb != 864) begin bad++; $display("FAIL multi_rd_cnt got=%0d exp=864", rd_q.size() - rb); end
    total++; if (wr_q.size() - wb != 384) begin bad++; $display("FAIL multi_wr_cnt got=%0d exp=384", wr_q.size() - wb); end
    if (clr_q.size() - cb == 6 && rd_q.size() - rb == 864 && ev_q.size() - eb == 864 && wr_q.size() - wb == 384) begin
      nb_c = 0; nb_r = 0; nb_a = 0; nb_d = 0; nb_k = 0;
      for (int p = 0; p < 6; p++) begin
        sel = {4'(p / 3), 4'(p % 3)};
        if (clr_q[cb+p] !== sel) begin
          if (nb_c == 0) $display("FAIL multi_sel pass=%0d got=%h exp=%h", p, clr_q[cb+p], sel);
          nb_c++;
        end
        for (int i = 0; i < 144; i++)
          if (rd_q[rb+p*144+i] !== 12'((p % 3) * 144 + i) || ev_q[eb+p*144+i] !== 16'((p % 3) * 144 + i)) begin
            if (nb_r == 0) $display("FAIL multi_rd pass=%0d idx=%0d got addr=%0d data=%0d exp=%0d",
                                    p, i, rd_q[rb+p*144+i], ev_q[eb+p*144+i], (p % 3) * 144 + i);
            nb_r++;
          end
        for (int k = 0; k < 64; k++) begin
          ed = {8'h00, sel, 16'(pix_of(k))};
          if (wr_q[wb+p*64+k].a !== 12'((p / 3) * 64 + k)) begin
            if (nb_a == 0) $display("FAIL multi_wr_addr pass=%0d idx=%0d got=%0d exp=%0d", p, k, wr_q[wb+p*64+k].a, (p / 3) * 64 + k);
            nb_a++;
          end
          if (wr_q[wb+p*64+k].d !== ed) begin
            if (nb_d == 0) $display("FAIL multi_wr_data pass=%0d idx=%0d got=%h exp=%h", p, k, wr_q[wb+p*64+k].d, ed);
            nb_d++;
          end
          if (wr_q[wb+p*64+k].acc !== ((p % 3) != 0)) begin
            if (nb_k == 0) $display("FAIL multi_wr_acc pass=%0d idx=%0d got=%b exp=%b", p, k, wr_q[wb+p*64+k].acc, (p % 3) != 0);
            nb_k++;
          end
        end
      end
      total++; if (nb_c != 0) bad++;
      total++; if (nb_r != 0) bad++;
      total++; if (nb_a != 0) bad++;
      total++; if (nb_d != 0) bad++;
      total++; if (nb_k != 0) bad++;
    end
  endtask

  task automatic test_start_ignored();
    int rb, wb, cb, db;
    bit got;
    mode = M_NORMAL;
    rb = rd_q.size(); wb = wr_q.size(); cb = clr_q.size(); db = done_cnt;
    do_start(4'd0, 4'd0);
    repeat (50) @(negedge clk);
    total++; if (fm_rd_en !== 1'b1) begin bad++; $display("FAIL ign_in_stream got=%b exp=1", fm_rd_en); end
    start = 1'b1; num_in_ch = 4'd3; num_out_ch = 4'd2;
    @(negedge clk);
    start = 1'b0; num_in_ch = 4'd0; num_out_ch = 4'd0;
    wait_done(400, got);
    total++; if (!got) begin bad++; $display("FAIL ign_done_wait got=timeout exp=done"); end
    repeat (20) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy got=%b exp=0", busy); end
    total++; if (done_cnt - db != 1) begin bad++; $display("FAIL ign_done_cnt got=%0d exp=1", done_cnt - db); end
    total++; if (rd_q.size() - rb != 144) begin bad++; $display("FAIL ign_rd_cnt got=%0d exp=144", rd_q.size() - rb); end
    total++; if (wr_q.size() - wb != 64) begin bad++; $display("FAIL ign_wr_cnt got=%0d exp=64", wr_q.size() - wb); end
    total++; if (clr_q.size() - cb != 1) begin bad++; $display("FAIL ign_clr_cnt got=%0d exp=1", clr_q.size() - cb); end
  endtask

  task automatic test_reset_mid();
    int rb, wb, db;
    bit got;
    mode = M_NORMAL;
    rb = rd_q.size(); db = done_cnt;
    do_start(4'd1, 4'd0);
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rd_q.size() >= rb + 288) begin got = 1'b1; break; end
    end
    total++; if (!got) begin bad++; $display("FAIL rmid_pass2_wait got=timeout exp=288 reads"); end
    @(negedge clk);
    total++; if (busy !== 1'b1 || fm_rd_en !== 1'b0) begin bad++; $display("FAIL rmid_in_drain got busy=%b rd=%b exp busy=1 rd=0", busy, fm_rd_en); end
    reset = 1'b1;
    #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rmid_wr_gate got=%b exp=0", wr_en); end
    @(negedge clk);
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (wr_en !== 1'b0)     begin bad++; $display("FAIL rmid_wr_en got=%b exp=0", wr_en); end
    total++; if (eng_reset !== 1'b1) begin bad++; $display("FAIL rmid_eng_reset got=%b exp=1", eng_reset); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_idle got busy=%b exp=0", busy); end
    total++; if (done_cnt != db) begin bad++; $display("FAIL rmid_no_done got=%0d exp=%0d", done_cnt, db); end
    wb = wr_q.size();
    do_start(4'd0, 4'd0);
    wait_done(400, got);
    total++; if (!got) begin bad++; $display("FAIL rmid_rerun_wait got=timeout exp=done"); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rmid_rerun_err got=%b exp=0", err); end
    @(negedge clk);
    total++; if (wr_q.size() - wb != 64) begin bad++; $display("FAIL rmid_rerun_wr got=%0d exp=64", wr_q.size() - wb); end
  endtask

  task automatic test_short();
    int wb;
    bit got;
    mode = M_SHORT;
    wb = wr_q.size();
    do_start(4'd0, 4'd0);
    wait_done(400, got);
    total++; if (!got) begin bad++; $display("FAIL short_done_wait got=timeout exp=done"); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL short_err_done got=%b exp=1", err); end
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL short_err_sticky got=%b exp=1", err); end
    total++; if (wr_q.size() - wb != 63) begin bad++; $display("FAIL short_wr_cnt got=%0d exp=63", wr_q.size() - wb); end
    mode = M_NORMAL;
    do_start(4'd0, 4'd0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL short_err_clear got=%b exp=0", err); end
    wait_done(400, got);
    total++; if (!got || err !== 1'b0) begin bad++; $display("FAIL short_rerun got done=%b err=%b exp done=1 err=0", got, err); end
  endtask

  task automatic test_timeout();
    int wb, n;
    bit got, seen;
    mode = M_NOFIN;
    wb = wr_q.size();
    do_start(4'd0, 4'd0);
    seen = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fm_rd_en === 1'b1) seen = 1'b1;
      else if (seen) begin got = 1'b1; break; end
    end
    total++; if (!got) begin bad++; $display("FAIL tmo_drain_wait got=timeout exp=drain"); end
    n = 0;
    while (err !== 1'b1 && n < 700) begin
      @(negedge clk);
      n++;
    end
    total++; if (n != 576) begin bad++; $display("FAIL tmo_cycles got=%0d exp=576", n); end
    wait_done(20, got);
    total++; if (!got) begin bad++; $display("FAIL tmo_done_wait got=timeout exp=done"); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err_done got=%b exp=1", err); end
    @(negedge clk);
    total++; if (wr_q.size() - wb != 64) begin bad++; $display("FAIL tmo_wr_cnt got=%0d exp=64", wr_q.size() - wb); end
    mode = M_NORMAL;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_start_ignored();
    test_reset_mid();
    test_short();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
